// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (I fetch, D load/store), the arbiter
// and the unified memory.
//   slave  : arbiter side. It takes the request fields and mem_dout, and drives
//            the gnt/rvalid/rdata signals and the memory command signals.
//   master : environment side (requesters plus memory), with directions mirrored.
interface mem_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [DATA_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_din, mem_read, mem_write
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_din, mem_read, mem_write
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter that serialises instruction fetches (I) and loads/stores (D) onto a
// single unified memory. Each access has a fixed latency:
//   cycle 0         gnt (combinational)
//   cycles 1..L+1   ACCESS, where L = MEM_LAT
//   cycle L+2       rvalid
// Ports:
//   clk   rising-edge clock
//   reset asynchronous, active-low reset
//   bus   mem_arbiter_if.slave (request/response handshakes and memory command)
//   busy  high whenever the FSM is not in IDLE
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: when both requesters contend,
// the one that was not granted last wins. Without the macro, D has fixed
// priority over I.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned DATA_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;      // 1 = D, 0 = I
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              busy_q, busy_d;
    logic              grant_c;
    logic              win_d_c;

    assign grant_c = (state_q == IDLE) && (bus.i_req || bus.d_req);

    // Arbitration: D wins unless round-robin hands the slot to I.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    assign win_d_c      = bus.d_req && (!bus.i_req || !last_owner_q);
    assign last_owner_d = grant_c ? win_d_c : last_owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_owner_q <= 1'b0;
        else        last_owner_q <= last_owner_d;
    end
`else
    assign win_d_c = bus.d_req;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(MEM_LAT);
                end
            end
            ACCESS: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: combinational grants plus the next values of the registered outputs
    always_comb begin
        bus.i_gnt = 1'b0;
        bus.d_gnt = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        owner_d   = owner_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    bus.d_gnt = win_d_c;
                    bus.i_gnt = !win_d_c;
                    owner_d   = win_d_c;
                    addr_d    = win_d_c ? bus.d_addr : bus.i_addr;
                    wdata_d   = win_d_c ? bus.d_wdata : '0;
                    we_d      = win_d_c && bus.d_we;
                end
            end
            ACCESS: begin
                // Stores return 0 so a stale load value never looks like a store result.
                if (cnt_q == '0) begin
                    if (owner_q) d_rdata_d = we_q ? '0 : bus.mem_dout;
                    else         i_rdata_d = bus.mem_dout;
                end
            end
            default: ;
        endcase
        // Registered strobes are decoded from the next state, so each one lines up with that state.
        mem_read_d  = (state_d == ACCESS) && !we_d;
        mem_write_d = (state_d == ACCESS) && we_d && (cnt_d == '0);
        i_rvalid_d  = (state_d == DONE) && !owner_d;
        d_rvalid_d  = (state_d == DONE) && owner_d;
        busy_d      = (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            owner_q     <= owner_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = wdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Three instances are built, with
// MEM_LAT = 1, 3 and 0; each has its own behavioural memory.
module tb_mem_arbiter;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic          own;   // 1 = D, 0 = I
        logic [DW-1:0] data;
    } exp_t;

    logic          clk    = 1'b0;
    logic          rst1_n = 1'b1;
    logic          rst3_n = 1'b1;
    logic          rst0_n = 1'b1;
    logic          busy1, busy3, busy0;
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] mem3 [256];
    logic [DW-1:0] mem0 [256];
    exp_t          sb [$];
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(DW)) b1 ();
    mem_arbiter_if #(.DATA_W(DW)) b3 ();
    mem_arbiter_if #(.DATA_W(DW)) b0 ();

    mem_arbiter #(.MEM_LAT(1), .DATA_W(DW)) u_lat1 (.clk(clk), .reset(rst1_n), .bus(b1.slave), .busy(busy1));
    mem_arbiter #(.MEM_LAT(3), .DATA_W(DW)) u_lat3 (.clk(clk), .reset(rst3_n), .bus(b3.slave), .busy(busy3));
    mem_arbiter #(.MEM_LAT(0), .DATA_W(DW)) u_lat0 (.clk(clk), .reset(rst0_n), .bus(b0.slave), .busy(busy0));

    // Memories: combinational read, write on the clock edge while mem_write is high
    assign b1.mem_dout = mem1[b1.mem_addr[9:2]];
    assign b3.mem_dout = mem3[b3.mem_addr[9:2]];
    assign b0.mem_dout = mem0[b0.mem_addr[9:2]];
    always @(posedge clk) if (b1.mem_write === 1'b1) mem1[b1.mem_addr[9:2]] = b1.mem_din;
    always @(posedge clk) if (b3.mem_write === 1'b1) mem3[b3.mem_addr[9:2]] = b3.mem_din;
    always @(posedge clk) if (b0.mem_write === 1'b1) mem0[b0.mem_addr[9:2]] = b0.mem_din;

    task automatic pulse_reset1();
        rst1_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst1_n = 1'b1;
    endtask

    // Drive one request on b1 and record what happens; the caller does the checking.
    task automatic access1(input logic own, input logic we, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wdata, output int gnt_c, output int rv_c,
                           output logic [DW-1:0] rdata, output int wr_n, output int rd_n);
        logic granted;
        granted = 1'b0;
        gnt_c = -1; rv_c = -1; rdata = 'x; wr_n = 0; rd_n = 0;
        if (own) begin b1.d_req = 1'b1; b1.d_we = we; b1.d_addr = addr; b1.d_wdata = wdata; end
        else     begin b1.i_req = 1'b1; b1.i_addr = addr; end
        for (int c = 0; c < 20 && rv_c < 0; c++) begin
            @(negedge clk);
            if (b1.mem_write === 1'b1) wr_n++;
            if (b1.mem_read === 1'b1) rd_n++;
            if (!granted && ((own ? b1.d_gnt : b1.i_gnt) === 1'b1)) begin gnt_c = c; granted = 1'b1; end
            if ((own ? b1.d_rvalid : b1.i_rvalid) === 1'b1) begin
                rv_c  = c;
                rdata = own ? b1.d_rdata : b1.i_rdata;
            end
            @(posedge clk); #1;
            if (granted) begin
                if (own) b1.d_req = 1'b0;
                else     b1.i_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst1_n = 1'b0;
        #1;
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
        total++;
        if ({b1.i_gnt, b1.d_gnt, b1.i_rvalid, b1.d_rvalid, b1.mem_read, b1.mem_write} !== 6'b0) begin
            bad++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {b1.i_gnt, b1.d_gnt, b1.i_rvalid, b1.d_rvalid, b1.mem_read, b1.mem_write});
        end
        total++;
        if ({b1.i_rdata, b1.d_rdata, b1.mem_addr, b1.mem_din} !== 128'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {b1.i_rdata, b1.d_rdata, b1.mem_addr, b1.mem_din});
        end
        repeat (2) @(posedge clk);
        #1 rst1_n = 1'b1;
    endtask

    task automatic test_fetch();
        int g, r, wn, rn;
        logic [DW-1:0] rd;
        exp_t e;
        mem1[4] = 32'h1234_5678;
        pulse_reset1();
        sb.push_back('{own: 1'b0, data: 32'h1234_5678});
        access1(1'b0, 1'b0, 32'h10, '0, g, r, rd, wn, rn);
        total++; if (g !== 0)  begin bad++; $display("FAIL fetch_gnt_cycle: got %0d want 0", g); end
        total++; if (r !== 3)  begin bad++; $display("FAIL fetch_rvalid_cycle: got %0d want 3", r); end
        total++; if (rn !== 2) begin bad++; $display("FAIL fetch_mem_read_cycles: got %0d want 2", rn); end
        total++; if (wn !== 0) begin bad++; $display("FAIL fetch_mem_write_cycles: got %0d want 0", wn); end
        e = sb.pop_front();
        total++; if (rd !== e.data) begin bad++; $display("FAIL fetch_rdata: got %h want %h", rd, e.data); end
    endtask

    task automatic test_store_load();
        int g, r, wn, rn;
        logic [DW-1:0] rd;
        exp_t e;
        sb.push_back('{own: 1'b1, data: 32'h0});
        access1(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, g, r, rd, wn, rn);
        total++; if (wn !== 1) begin bad++; $display("FAIL store_mem_write_cycles: got %0d want 1", wn); end
        total++; if (rn !== 0) begin bad++; $display("FAIL store_mem_read_cycles: got %0d want 0", rn); end
        total++; if (r - g !== 3) begin bad++; $display("FAIL store_latency: got %0d want 3", r - g); end
        e = sb.pop_front();
        total++; if (rd !== e.data) begin bad++; $display("FAIL store_rdata: got %h want %h", rd, e.data); end
        total++; if (mem1[16] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_mem_word: got %h want deadbeef", mem1[16]); end
        sb.push_back('{own: 1'b1, data: 32'hDEAD_BEEF});
        access1(1'b1, 1'b0, 32'h40, '0, g, r, rd, wn, rn);
        total++; if (wn !== 0) begin bad++; $display("FAIL load_mem_write_cycles: got %0d want 0", wn); end
        e = sb.pop_front();
        total++; if (rd !== e.data) begin bad++; $display("FAIL load_rdata: got %h want %h", rd, e.data); end
    endtask

    task automatic test_priority();
        int dg, ig, n_rv, both;
        int rvc [2];
        exp_t e;
        pulse_reset1();
        dg = -1; ig = -1; n_rv = 0; both = 0; rvc[0] = -1; rvc[1] = -1;
        sb.push_back('{own: 1'b1, data: 32'hDEAD_BEEF});
        sb.push_back('{own: 1'b0, data: 32'h1234_5678});
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h40;
        b1.i_req = 1'b1; b1.i_addr = 32'h10;
        for (int c = 0; c < 20 && n_rv < 2; c++) begin
            @(negedge clk);
            if (b1.i_gnt === 1'b1 && b1.d_gnt === 1'b1) both++;
            if (b1.i_rvalid === 1'b1 && b1.d_rvalid === 1'b1) both++;
            if (b1.d_gnt === 1'b1 && dg < 0) dg = c;
            if (b1.i_gnt === 1'b1 && ig < 0) ig = c;
            if (b1.i_rvalid === 1'b1 || b1.d_rvalid === 1'b1) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    total++;
                    if ({b1.d_rvalid, (b1.d_rvalid ? b1.d_rdata : b1.i_rdata)} !== {e.own, e.data}) begin
                        bad++;
                        $display("FAIL prio_response: got own=%b data=%h want own=%b data=%h",
                                 b1.d_rvalid, (b1.d_rvalid ? b1.d_rdata : b1.i_rdata), e.own, e.data);
                    end
                end
                rvc[n_rv] = c;
                n_rv++;
            end
            @(posedge clk); #1;
            if (dg >= 0) b1.d_req = 1'b0;
            if (ig >= 0) b1.i_req = 1'b0;
        end
        b1.d_req = 1'b0; b1.i_req = 1'b0;
        total++; if (dg !== 0) begin bad++; $display("FAIL prio_d_gnt_cycle: got %0d want 0", dg); end
        total++; if (ig !== 4) begin bad++; $display("FAIL prio_i_gnt_cycle: got %0d want 4", ig); end
        total++; if (both !== 0) begin bad++; $display("FAIL prio_overlap: got %0d want 0", both); end
        total++; if (rvc[0] !== 3 || rvc[1] !== 7) begin bad++; $display("FAIL prio_rvalid_cycles: got %0d,%0d want 3,7", rvc[0], rvc[1]); end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        logic own_exp [4];
        int gc [4];
        int ngnt, n_rv, both;
        exp_t e;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        own_exp[0] = 1'b1; own_exp[1] = 1'b0; own_exp[2] = 1'b1; own_exp[3] = 1'b0;
`else
        own_exp[0] = 1'b1; own_exp[1] = 1'b1; own_exp[2] = 1'b1; own_exp[3] = 1'b1;
`endif
        pulse_reset1();
        ngnt = 0; n_rv = 0; both = 0;
        for (int k = 0; k < 4; k++) begin
            gc[k] = -1;
            sb.push_back('{own: own_exp[k], data: (own_exp[k] ? 32'hDEAD_BEEF : 32'h1234_5678)});
        end
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h40;
        b1.i_req = 1'b1; b1.i_addr = 32'h10;
        for (int c = 0; c < 40 && n_rv < 4; c++) begin
            @(negedge clk);
            if (b1.i_gnt === 1'b1 && b1.d_gnt === 1'b1) both++;
            if (b1.i_rvalid === 1'b1 && b1.d_rvalid === 1'b1) both++;
            if (b1.i_gnt === 1'b1 || b1.d_gnt === 1'b1) begin
                if (ngnt < 4) gc[ngnt] = c;
                ngnt++;
            end
            if (b1.i_rvalid === 1'b1 || b1.d_rvalid === 1'b1) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    total++;
                    if ({b1.d_rvalid, (b1.d_rvalid ? b1.d_rdata : b1.i_rdata)} !== {e.own, e.data}) begin
                        bad++;
                        $display("FAIL b2b_response%0d: got own=%b data=%h want own=%b data=%h", n_rv,
                                 b1.d_rvalid, (b1.d_rvalid ? b1.d_rdata : b1.i_rdata), e.own, e.data);
                    end
                end
                n_rv++;
            end
            @(posedge clk); #1;
            if (ngnt >= 4) begin b1.d_req = 1'b0; b1.i_req = 1'b0; end
        end
        b1.d_req = 1'b0; b1.i_req = 1'b0;
        total++; if (n_rv !== 4) begin bad++; $display("FAIL b2b_rvalid_count: got %0d want 4", n_rv); end
        total++; if (ngnt !== 4) begin bad++; $display("FAIL b2b_gnt_count: got %0d want 4", ngnt); end
        total++; if (gc[1] !== 4 || gc[3] !== 12) begin bad++; $display("FAIL b2b_gnt_spacing: got %0d,%0d want 4,12", gc[1], gc[3]); end
        total++; if (both !== 0) begin bad++; $display("FAIL b2b_overlap: got %0d want 0", both); end
        sb.delete();
    endtask

    task automatic test_reset_abort();
        int rv_n, wr_n, g, r;
        exp_t e;
        mem3[32] = 32'h0;
        rst3_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst3_n = 1'b1;
        b3.d_req = 1'b1; b3.d_we = 1'b1; b3.d_addr = 32'h80; b3.d_wdata = 32'hAAAA_5555;
        @(negedge clk);
        total++; if (b3.d_gnt !== 1'b1) begin bad++; $display("FAIL abort_gnt: got %b want 1", b3.d_gnt); end
        @(posedge clk); #1;
        b3.d_req = 1'b0; b3.d_we = 1'b0;
        @(posedge clk); #2;
        total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL abort_busy_pre: got %b want 1", busy3); end
        rst3_n = 1'b0;
        #1;
        total++;
        if ({busy3, b3.mem_read, b3.mem_write, b3.d_rvalid} !== 4'b0) begin
            bad++;
            $display("FAIL abort_async_clear: got %b want 0000", {busy3, b3.mem_read, b3.mem_write, b3.d_rvalid});
        end
        rv_n = 0; wr_n = 0;
        repeat (2) begin
            @(negedge clk);
            if (b3.d_rvalid !== 1'b0) rv_n++;
            if (b3.mem_write !== 1'b0) wr_n++;
        end
        @(posedge clk); #1 rst3_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (b3.d_rvalid !== 1'b0) rv_n++;
            if (b3.mem_write !== 1'b0) wr_n++;
        end
        @(posedge clk); #1;
        total++; if (rv_n !== 0 || wr_n !== 0) begin bad++; $display("FAIL abort_no_activity: got rvalid=%0d write=%0d want 0,0", rv_n, wr_n); end
        total++; if (mem3[32] !== 32'h0) begin bad++; $display("FAIL abort_mem_word: got %h want 0", mem3[32]); end
        sb.push_back('{own: 1'b1, data: 32'h0});
        g = -1; r = -1;
        b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h80;
        for (int c = 0; c < 20 && r < 0; c++) begin
            @(negedge clk);
            if (b3.d_gnt === 1'b1 && g < 0) g = c;
            if (b3.d_rvalid === 1'b1) begin
                r = c;
                e = sb.pop_front();
                total++; if (b3.d_rdata !== e.data) begin bad++; $display("FAIL abort_reload_rdata: got %h want %h", b3.d_rdata, e.data); end
            end
            @(posedge clk); #1;
            if (g >= 0) b3.d_req = 1'b0;
        end
        b3.d_req = 1'b0;
        total++; if (g !== 0 || r !== 5) begin bad++; $display("FAIL abort_reload_timing: got gnt=%0d rvalid=%0d want 0,5", g, r); end
        sb.delete();
    endtask

    task automatic test_lat0();
        int g, r, busy_n;
        exp_t e;
        mem0[4] = 32'hCAFE_F00D;
        rst0_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst0_n = 1'b1;
        sb.push_back('{own: 1'b0, data: 32'hCAFE_F00D});
        g = -1; r = -1; busy_n = 0;
        b0.i_req = 1'b1; b0.i_addr = 32'h10;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (busy0 === 1'b1) busy_n++;
            if (b0.i_gnt === 1'b1 && g < 0) g = c;
            if (b0.i_rvalid === 1'b1) begin
                r = c;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    total++; if (b0.i_rdata !== e.data) begin bad++; $display("FAIL lat0_rdata: got %h want %h", b0.i_rdata, e.data); end
                end
            end
            @(posedge clk); #1;
            if (g >= 0) b0.i_req = 1'b0;
        end
        total++; if (g !== 0) begin bad++; $display("FAIL lat0_gnt_cycle: got %0d want 0", g); end
        total++; if (r !== 2) begin bad++; $display("FAIL lat0_rvalid_cycle: got %0d want 2", r); end
        total++; if (busy_n !== 2) begin bad++; $display("FAIL lat0_busy_cycles: got %0d want 2", busy_n); end
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem1[i] = '0; mem3[i] = '0; mem0[i] = '0; end
        b1.i_req = 1'b0; b1.i_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
        b3.i_req = 1'b0; b3.i_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;
        b0.i_req = 1'b0; b0.i_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0;
        #2;
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_back_to_back();
        test_reset_abort();
        test_lat0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
